ddr_prog_dly_se_cfg_seq: RTL and testbench
==========================================

Name: ddr_prog_dly_se_cfg_seq

Overview:
Upstream configuration sequencer for the single-ended programmable delay cell. It accepts a new target delay configuration (ctrl code, enable, gear) through a four-phase req/ack handshake. It drives the cell's PWIDTH-bit config bus so the delay moves glitch-safely: ctrl is stepped one LSB at a time while the cell is enabled, and the cell is disabled around any gear change. It sits between the CSR/training logic and the delay-cell wrapper, clocked on the DFI-side register clock.

Parameters:
CTRL_W, 6, width of the binary ctrl code field
GEAR_W, 2, width of the gear field
PWIDTH, 9, config bus width; must equal CTRL_W+1+GEAR_W
STEP_DLY_W, 4, width of the per-step settle-time field

Ports:
i_clk  input  1  register clock
i_rst  input  1  synchronous, active-high reset
i_req  input  1  update request; four-phase, held until o_ack
i_tgt_ctrl  input  CTRL_W  target ctrl code
i_tgt_en  input  1  target enable
i_tgt_gear  input  GEAR_W  target gear
i_step_dly  input  STEP_DLY_W  settle cycles per step, minus 1
o_busy  output  1  transaction in progress
o_ack  output  1  transaction complete; held until i_req drops
o_prog_dly_cfg  output  PWIDTH  {gear[GEAR_W-1:0], en, ctrl[CTRL_W-1:0]}; ctrl at LSBs, en at bit CTRL_W

Behaviour:
- All state is registered on i_clk. Reset, synchronous on i_rst, applies in every state including mid-transaction:
  - o_prog_dly_cfg=0, o_busy=0, o_ack=0, FSM=IDLE.
- States: IDLE, STEP, DIS, LOAD, ENA, DONE.
- IDLE:
  - On i_req=1, latch i_tgt_* and i_step_dly, and set o_busy=1 in the next cycle.
  - Route from current config (cur) to target (tgt):
    - cur==tgt: go to DONE.
    - cur.en=1, tgt.en=1, gear equal: go to STEP.
    - Otherwise: go to DIS if cur.en=1, else LOAD.
- Wait counter: every STEP/DIS/LOAD/ENA action is followed by a hold of step_dly+1 cycles before the next action. step_dly=0 gives 1 cycle per action.
- STEP: ctrl moves ±1 toward tgt.ctrl per action. When ctrl==tgt.ctrl after the hold, go to DONE. There is no wrap-around; ctrl never passes 0 or 2^CTRL_W-1.
- DIS: set en=0. Then go to LOAD.
- LOAD: set gear=tgt.gear and ctrl=tgt.ctrl in a single write while en=0. Then go to ENA if tgt.en, else DONE.
- ENA: set en=1. Then go to DONE.
- DONE: o_ack=1, o_busy=1. When i_req=0, clear o_ack and o_busy in the next cycle and return to IDLE.
- Targets are sampled only in IDLE. Changes to i_tgt_* during a transaction are ignored.
- An i_req that stays high after o_ack is not re-accepted until it has been seen low.
- en never toggles in the same cycle as a gear or ctrl change.
- Latency for a STEP-only update: |Δctrl|·(step_dly+1) cycles after acceptance, plus 1 cycle to DONE.

Optional Feature:
DDR_PROG_DLY_SE_CFG_SEQ_BYPASS_EN
- Defined:
  - Adds input port i_bypass (1 bit).
  - While i_bypass=1, o_prog_dly_cfg = {i_tgt_gear, i_tgt_en, i_tgt_ctrl}, registered with 1-cycle latency. The FSM is forced to IDLE and o_busy=0, o_ack=0. Requests are ignored.
  - On i_bypass deassertion, the internal cur register holds the last bypass value.
- Undefined: the port is absent and the behaviour is as above.

Decomposition:
- ddr_global_pkg adds:
  - DDR_PROG_DLY_SE_CTRL_W, DDR_PROG_DLY_SE_GEAR_W and the field offsets.
  - Typedef prog_dly_cfg_t (packed struct gear/en/ctrl).
  - Enum prog_dly_seq_state_t.
- One sub-module, ddr_prog_dly_seq_wait_cnt: a loadable down-counter with a done flag, used for the settle holds.

Test Plan:
1. Reset, then req with ctrl=5, en=1, gear=0, step_dly=0 from all-zero: route DIS skipped, LOAD then ENA. o_prog_dly_cfg ends at 0x045. o_ack is asserted 4 cycles after acceptance.
2. From ctrl=5, en=1, req ctrl=9, step_dly=2: ctrl steps 6,7,8,9, each held 3 cycles, with en=1 throughout. o_ack follows.
3. From ctrl=9, gear=0, en=1, req gear=2, ctrl=3, en=1: sequence en=0, then {gear=2, ctrl=3}, then en=1. The bench checks no cycle has en=1 with a gear or ctrl change.
4. Req equal to the current config: o_ack=1 two cycles after acceptance and cfg unchanged. Holding i_req high for 10 cycles after ack produces no second transaction.
5. Assert i_rst during the STEP toward ctrl=40: the next cycle shows cfg=0, busy=0, ack=0. A new req then completes normally.
6. With the macro defined, i_bypass=1 and tgt 0x1FF: o_prog_dly_cfg=0x1FF one cycle later. Bypass drops, and a req to ctrl=0x3E steps down by 1.

Source files
------------

// File: rtl/ddr_global_pkg.sv
// rtl/ddr_global_pkg.sv - shared DDR PHY types; prog delay cell config layout and sequencer states
package ddr_global_pkg;

  localparam int DDR_PROG_DLY_SE_CTRL_W   = 6;
  localparam int DDR_PROG_DLY_SE_GEAR_W   = 2;
  localparam int DDR_PROG_DLY_SE_CTRL_OFS = 0;
  localparam int DDR_PROG_DLY_SE_EN_OFS   = DDR_PROG_DLY_SE_CTRL_W;
  localparam int DDR_PROG_DLY_SE_GEAR_OFS = DDR_PROG_DLY_SE_CTRL_W + 1;
  localparam int DDR_PROG_DLY_SE_PWIDTH   = DDR_PROG_DLY_SE_CTRL_W + 1 + DDR_PROG_DLY_SE_GEAR_W;

  typedef struct packed {
    logic [DDR_PROG_DLY_SE_GEAR_W-1:0] gear;
    logic                              en;
    logic [DDR_PROG_DLY_SE_CTRL_W-1:0] ctrl;
  } prog_dly_cfg_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_STEP,
    SEQ_DIS,
    SEQ_LOAD,
    SEQ_ENA,
    SEQ_DONE
  } prog_dly_seq_state_t;

endpackage

// File: rtl/ddr_prog_dly_seq_wait_cnt.sv
// rtl/ddr_prog_dly_seq_wait_cnt.sv - loadable settle down-counter; done while the count is zero
module ddr_prog_dly_seq_wait_cnt #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/ddr_prog_dly_se_cfg_seq.sv
// rtl/ddr_prog_dly_se_cfg_seq.sv - glitch-safe config sequencer for the single-ended prog delay cell
// Optional bypass path: DDR_PROG_DLY_SE_CFG_SEQ_BYPASS_EN
module ddr_prog_dly_se_cfg_seq
  import ddr_global_pkg::*;
#(
  parameter int CTRL_W     = DDR_PROG_DLY_SE_CTRL_W,
  parameter int GEAR_W     = DDR_PROG_DLY_SE_GEAR_W,
  parameter int PWIDTH     = DDR_PROG_DLY_SE_PWIDTH,
  parameter int STEP_DLY_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic [CTRL_W-1:0]     i_tgt_ctrl,
  input  logic                  i_tgt_en,
  input  logic [GEAR_W-1:0]     i_tgt_gear,
  input  logic [STEP_DLY_W-1:0] i_step_dly,
`ifdef DDR_PROG_DLY_SE_CFG_SEQ_BYPASS_EN
  input  logic                  i_bypass,
`endif
  output logic                  o_busy,
  output logic                  o_ack,
  output logic [PWIDTH-1:0]     o_prog_dly_cfg
);

  prog_dly_seq_state_t state_q, state_d;

  logic [CTRL_W-1:0]     cur_ctrl_q, cur_ctrl_d, tgt_ctrl_q, tgt_ctrl_d;
  logic                  cur_en_q, cur_en_d, tgt_en_q, tgt_en_d;
  logic [GEAR_W-1:0]     cur_gear_q, cur_gear_d, tgt_gear_q, tgt_gear_d;
  logic [STEP_DLY_W-1:0] dly_q, dly_d;
  logic                  busy_q, busy_d, ack_q, ack_d;
  logic                  cnt_load, cnt_done;
  logic [CTRL_W-1:0]     ctrl_step;

  // Target is never passed, so a single LSB move toward it cannot wrap.
  assign ctrl_step = (cur_ctrl_q < tgt_ctrl_q) ? cur_ctrl_q + CTRL_W'(1)
                                               : cur_ctrl_q - CTRL_W'(1);

  ddr_prog_dly_seq_wait_cnt #(.W(STEP_DLY_W)) u_wait_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (cnt_load),
    .i_load_val (dly_q),
    .o_done     (cnt_done)
  );

  always_comb begin
    state_d    = state_q;
    cur_ctrl_d = cur_ctrl_q;
    cur_en_d   = cur_en_q;
    cur_gear_d = cur_gear_q;
    tgt_ctrl_d = tgt_ctrl_q;
    tgt_en_d   = tgt_en_q;
    tgt_gear_d = tgt_gear_q;
    dly_d      = dly_q;
    busy_d     = busy_q;
    ack_d      = ack_q;
    cnt_load   = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (i_req) begin
          tgt_ctrl_d = i_tgt_ctrl;
          tgt_en_d   = i_tgt_en;
          tgt_gear_d = i_tgt_gear;
          dly_d      = i_step_dly;
          busy_d     = 1'b1;
          if (i_tgt_ctrl == cur_ctrl_q && i_tgt_en == cur_en_q && i_tgt_gear == cur_gear_q) begin
            state_d = SEQ_DONE;
          end else if (cur_en_q && i_tgt_en && i_tgt_gear == cur_gear_q) begin
            state_d = SEQ_STEP;
          end else if (cur_en_q) begin
            state_d = SEQ_DIS;
          end else begin
            state_d = SEQ_LOAD;
          end
        end
      end
      SEQ_STEP: begin
        if (cnt_done) begin
          cur_ctrl_d = ctrl_step;
          cnt_load   = 1'b1;
          if (ctrl_step == tgt_ctrl_q) begin
            state_d = SEQ_DONE;
          end
        end
      end
      SEQ_DIS: begin
        if (cnt_done) begin
          cur_en_d = 1'b0;
          cnt_load = 1'b1;
          state_d  = SEQ_LOAD;
        end
      end
      SEQ_LOAD: begin
        if (cnt_done) begin
          cur_ctrl_d = tgt_ctrl_q;
          cur_gear_d = tgt_gear_q;
          cnt_load   = 1'b1;
          state_d    = tgt_en_q ? SEQ_ENA : SEQ_DONE;
        end
      end
      SEQ_ENA: begin
        if (cnt_done) begin
          cur_en_d = 1'b1;
          cnt_load = 1'b1;
          state_d  = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        // The last action's settle hold runs here before ack is raised.
        if (!ack_q) begin
          if (cnt_done) begin
            ack_d = 1'b1;
          end
        end else if (!i_req) begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

`ifdef DDR_PROG_DLY_SE_CFG_SEQ_BYPASS_EN
    if (i_bypass) begin
      state_d    = SEQ_IDLE;
      busy_d     = 1'b0;
      ack_d      = 1'b0;
      cnt_load   = 1'b0;
      cur_ctrl_d = i_tgt_ctrl;
      cur_en_d   = i_tgt_en;
      cur_gear_d = i_tgt_gear;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= SEQ_IDLE;
      cur_ctrl_q <= '0;
      cur_en_q   <= 1'b0;
      cur_gear_q <= '0;
      tgt_ctrl_q <= '0;
      tgt_en_q   <= 1'b0;
      tgt_gear_q <= '0;
      dly_q      <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_ctrl_q <= cur_ctrl_d;
      cur_en_q   <= cur_en_d;
      cur_gear_q <= cur_gear_d;
      tgt_ctrl_q <= tgt_ctrl_d;
      tgt_en_q   <= tgt_en_d;
      tgt_gear_q <= tgt_gear_d;
      dly_q      <= dly_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_ack          = ack_q;
  assign o_prog_dly_cfg = {cur_gear_q, cur_en_q, cur_ctrl_q};

endmodule

// File: tb/tb_ddr_prog_dly_se_cfg_seq.sv
// tb/tb_ddr_prog_dly_se_cfg_seq.sv - randomized self-checking bench with a transaction-level reference model
module tb_ddr_prog_dly_se_cfg_seq;
  import ddr_global_pkg::*;

  logic       clk = 1'b0;
  logic       rst, req, tgt_en;
  logic [5:0] tgt_ctrl;
  logic [1:0] tgt_gear;
  logic [3:0] step_dly;
  logic       busy, ack;
  logic [8:0] cfg;
`ifdef DDR_PROG_DLY_SE_CFG_SEQ_BYPASS_EN
  logic       bypass = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  prog_dly_cfg_t model_cur = '0;

  always #5 clk = ~clk;

  ddr_prog_dly_se_cfg_seq dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .i_tgt_ctrl     (tgt_ctrl),
    .i_tgt_en       (tgt_en),
    .i_tgt_gear     (tgt_gear),
    .i_step_dly     (step_dly),
`ifdef DDR_PROG_DLY_SE_CFG_SEQ_BYPASS_EN
    .i_bypass       (bypass),
`endif
    .o_busy         (busy),
    .o_ack          (ack),
    .o_prog_dly_cfg (cfg)
  );

  // Reference: the list of config writes the spec's routing rules demand; write k lands
  // on cycle 2+k*(d+1) after acceptance and ack follows one full hold after the last write.
  task automatic run_txn(input prog_dly_cfg_t tgt, input int d, input int hold_after);
    prog_dly_cfg_t acts[$];
    prog_dly_cfg_t x, exp_cfg, prev, obs;
    int n, ackc, k;
    x = model_cur;
    if (model_cur == tgt) begin
    end else if (model_cur.en && tgt.en && model_cur.gear == tgt.gear) begin
      while (x.ctrl != tgt.ctrl) begin
        if (x.ctrl < tgt.ctrl) x.ctrl = x.ctrl + 6'd1;
        else                   x.ctrl = x.ctrl - 6'd1;
        acts.push_back(x);
      end
    end else begin
      if (model_cur.en) begin
        x.en = 1'b0;
        acts.push_back(x);
      end
      x.gear = tgt.gear;
      x.ctrl = tgt.ctrl;
      acts.push_back(x);
      if (tgt.en) begin
        x.en = 1'b1;
        acts.push_back(x);
      end
    end
    n    = acts.size();
    ackc = 2 + n * (d + 1);

    @(negedge clk);
    req = 1'b1; tgt_ctrl = tgt.ctrl; tgt_en = tgt.en; tgt_gear = tgt.gear; step_dly = 4'(d);
    prev = model_cur;
    for (int c = 1; c <= ackc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tgt_ctrl = 6'($urandom); tgt_en = 1'($urandom); tgt_gear = 2'($urandom);
        step_dly = 4'($urandom);
      end
      if (c < 2 || n == 0) exp_cfg = model_cur;
      else begin
        k = (c - 2) / (d + 1);
        if (k >= n) k = n - 1;
        exp_cfg = acts[k];
      end
      obs = cfg;
      n_vec++;
      if (cfg !== exp_cfg) begin
        n_err++; $display("FAIL txn_cfg cyc=%0d got=%h want=%h", c, cfg, exp_cfg);
      end
      n_vec++;
      if (ack !== (c == ackc)) begin
        n_err++; $display("FAIL txn_ack cyc=%0d got=%b want=%b", c, ack, (c == ackc));
      end
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++; $display("FAIL txn_busy cyc=%0d got=%b want=1", c, busy);
      end
      n_vec++;
      if (obs.en != prev.en && (obs.gear != prev.gear || obs.ctrl != prev.ctrl)) begin
        n_err++; $display("FAIL en_glitch cyc=%0d got=%h prev=%h want=no en+field change", c, obs, prev);
      end
      prev = obs;
    end
    for (int h = 0; h < hold_after; h++) begin
      @(negedge clk);
      n_vec++;
      if (ack !== 1'b1 || busy !== 1'b1 || cfg !== tgt) begin
        n_err++; $display("FAIL hold_ack h=%0d got ack=%b busy=%b cfg=%h want 1 1 %h", h, ack, busy, cfg, tgt);
      end
    end
    req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ack !== 1'b0 || busy !== 1'b0 || cfg !== tgt) begin
      n_err++; $display("FAIL release got ack=%b busy=%b cfg=%h want 0 0 %h", ack, busy, cfg, tgt);
    end
    model_cur = tgt;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; tgt_ctrl = '0; tgt_en = 1'b0; tgt_gear = '0; step_dly = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (cfg !== 9'h000 || busy !== 1'b0 || ack !== 1'b0) begin
      n_err++; $display("FAIL reset got cfg=%h busy=%b ack=%b want 000 0 0", cfg, busy, ack);
    end
    rst = 1'b0;
    model_cur = '0;
  endtask

  task automatic test_load_ena();
    run_txn('{gear: 2'd0, en: 1'b1, ctrl: 6'd5}, 0, 0);
    n_vec++;
    if (cfg !== 9'h045) begin
      n_err++; $display("FAIL load_ena_final got=%h want=045", cfg);
    end
  endtask

  task automatic test_step();
    run_txn('{gear: 2'd0, en: 1'b1, ctrl: 6'd9}, 2, 0);
  endtask

  task automatic test_gear_change();
    run_txn('{gear: 2'd2, en: 1'b1, ctrl: 6'd3}, 0, 0);
  endtask

  task automatic test_equal_hold();
    run_txn(model_cur, 1, 10);
  endtask

  task automatic test_reset_mid_step();
    @(negedge clk);
    req = 1'b1; tgt_ctrl = 6'd40; tgt_en = 1'b1; tgt_gear = model_cur.gear; step_dly = 4'd1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || ack !== 1'b0) begin
      n_err++; $display("FAIL mid_step got busy=%b ack=%b want 1 0", busy, ack);
    end
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cfg !== 9'h000 || busy !== 1'b0 || ack !== 1'b0) begin
      n_err++; $display("FAIL rst_mid got cfg=%h busy=%b ack=%b want 000 0 0", cfg, busy, ack);
    end
    rst = 1'b0;
    model_cur = '0;
    run_txn('{gear: 2'd1, en: 1'b1, ctrl: 6'd12}, 0, 0);
  endtask

  task automatic test_random();
    prog_dly_cfg_t t;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 5) == 0) t = model_cur;
      else if ($urandom_range(0, 1) == 0) begin
        t = model_cur;
        t.en = 1'b1;
        t.ctrl = 6'($urandom);
      end else t = 9'($urandom);
      run_txn(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
  endtask

`ifdef DDR_PROG_DLY_SE_CFG_SEQ_BYPASS_EN
  task automatic test_bypass();
    @(negedge clk);
    bypass = 1'b1; req = 1'b1; tgt_ctrl = 6'h3F; tgt_en = 1'b1; tgt_gear = 2'h3; step_dly = 4'd0;
    @(negedge clk);
    n_vec++;
    if (cfg !== 9'h1FF || busy !== 1'b0 || ack !== 1'b0) begin
      n_err++; $display("FAIL bypass got cfg=%h busy=%b ack=%b want 1ff 0 0", cfg, busy, ack);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      n_err++; $display("FAIL bypass_req got busy=%b ack=%b want 0 0", busy, ack);
    end
    req = 1'b0;
    @(negedge clk);
    bypass = 1'b0;
    model_cur = 9'h1FF;
    run_txn('{gear: 2'd3, en: 1'b1, ctrl: 6'h3E}, 0, 0);
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_ena();
    test_step();
    test_gear_change();
    test_equal_hold();
    test_reset_mid_step();
    test_random();
`ifdef DDR_PROG_DLY_SE_CFG_SEQ_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
